ram_loader: RTL

Sequential programmer for the SAP-1 16x4 latch RAM. It drives the RAM's active-low chip-enable, active-low write-enable, address and data-in pins, and samples the RAM data-out. It takes a 4-bit word stream over a valid/ready handshake and writes it to addresses 0..15 in order, with a setup/strobe/hold sequence suited to level-sensitive latch cells. It can then read every location back and compare it against a shadow copy of what was written. It replaces the manual switch-programming path of the SAP-1 front panel.

---
 rtl/ram_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
`timescale 1ns/1ps
// ram_loader: streams 16 words into the SAP-1 16x4 latch RAM with a
// setup/strobe/hold write sequence and an optional read-back verify pass.
module ram_loader #(
  parameter int unsigned VERIFY = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic [3:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       CE_N,
  output logic       WE_N,
  output logic [3:0] A,
  output logic [3:0] D,
  input  logic [3:0] S,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [3:0] ERR_ADDR
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    W_SETUP   = 3'd2,
    W_STROBE  = 3'd3,
    W_HOLD    = 3'd4,
    V_ADDR    = 3'd5,
    V_SAMPLE  = 3'd6
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] shadow [16];

  // Shadow copy of every accepted word; intentionally left out of reset.
  always_ff @(posedge CLK) begin
    if (!CLR && state == WAIT_DATA && DIN_VALID) begin
      shadow[cnt] <= DIN;
    end
  end

  // Loader FSM; each transition also sets the registered pin values of the next state.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      CE_N      <= 1'b1;
      WE_N      <= 1'b1;
      A         <= 4'd0;
      D         <= 4'd0;
      DIN_READY <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      ERR_ADDR  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state     <= WAIT_DATA;
            cnt       <= 4'd0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            ERR_ADDR  <= 4'd0;
            BUSY      <= 1'b1;
            DIN_READY <= 1'b1;
          end
        end
        WAIT_DATA: begin
          if (DIN_VALID) begin
            D         <= DIN;
            A         <= cnt;
            CE_N      <= 1'b0;
            DIN_READY <= 1'b0;
            state     <= W_SETUP;
          end
        end
        W_SETUP: begin
          WE_N  <= 1'b0;
          state <= W_STROBE;
        end
        W_STROBE: begin
          // Release both strobes together; A and D stay put for the hold cycle.
          CE_N  <= 1'b1;
          WE_N  <= 1'b1;
          state <= W_HOLD;
        end
        W_HOLD: begin
          if (cnt == 4'd15) begin
            cnt <= 4'd0;
            if (VERIFY != 0) begin
              A     <= 4'd0;
              CE_N  <= 1'b0;
              state <= V_ADDR;
            end else begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt       <= cnt + 4'd1;
            DIN_READY <= 1'b1;
            state     <= WAIT_DATA;
          end
        end
        V_ADDR: begin
          state <= V_SAMPLE;
        end
        V_SAMPLE: begin
          if ((S != shadow[cnt]) && !ERR) begin
            ERR      <= 1'b1;
            ERR_ADDR <= cnt;
          end
          if (cnt == 4'd15) begin
            cnt   <= 4'd0;
            CE_N  <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt   <= cnt + 4'd1;
            A     <= cnt + 4'd1;
            state <= V_ADDR;
          end
        end
        default: begin
          state     <= IDLE;
          CE_N      <= 1'b1;
          WE_N      <= 1'b1;
          BUSY      <= 1'b0;
          DIN_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule
